pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Serial pattern transmitter that drives the single-bit `x` stream consumed by the sequence-detector blocks. It accepts a parallel pattern and length through a valid/ready load port and shifts the pattern out MSB-first, one bit per clock. It can optionally repeat the pattern back-to-back. Between patterns it holds the line at the neutral level 1, which keeps a downstream detector in its initial state.

## Interface
- `MAXLEN`, default 8: maximum pattern length in bits; legal range 1..15.
- `LENW`, default 4: width of `len`; must satisfy MAXLEN ≤ 2^LENW − 1.
- `REPW`, default 2: width of `repeat_cnt`.

- `clk`  in  1: clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `load_valid`  in  1: a pattern is offered on `pattern` / `len` / `repeat_cnt`.
- `load_ready`  out  1: block can accept a pattern (high only in IDLE).
- `pattern`  in  MAXLEN: bits to send; bit `len-1` is sent first, bit 0 last.
- `len`  in  LENW: number of bits to send per pass.
- `repeat_cnt`  in  REPW: extra passes after the first (total passes = repeat_cnt + 1).
- `x`  out  1: registered serial output; 1 when idle.
- `bit_valid`  out  1: high in every cycle in which `x` carries a pattern bit.
- `busy`  out  1: high in SHIFT state.
- `done`  out  1: one-cycle pulse after the last bit of the last pass.

## Operation
- States:
  - IDLE: `load_ready`=1, `x`=1, `bit_valid`=0.
  - SHIFT: emitting bits.
- Accept: `load_valid && load_ready` at a rising edge.
  - Captures `pattern`, effective length, and repeat count into internal registers.
  - Inputs are don't-care at all other times.
- Effective length:
  - `len` > MAXLEN is clamped to MAXLEN.
  - `len` == 0 emits no bits and is handled as in Timing.
- SHIFT behaviour:
  - Bit index counts down from effLen−1 to 0.
  - `x` = captured pattern[index]; `bit_valid`=1.
- On index 0:
  - If remaining passes > 0: decrement remaining passes, reload index to effLen−1, stay in SHIFT. There is no gap between passes.
  - Otherwise: next state is IDLE.
- `done` is asserted for exactly one cycle, in the first IDLE cycle after SHIFT ends.
- Counter arithmetic:
  - Index counter is LENW bits wide.
  - Pass counter is REPW bits wide.
  - Counters only decrement and never wrap; wrap-around is impossible by construction.
- Reset:
  - Takes effect at any point, including mid-pattern.
  - Next state is IDLE; `x`=1, `bit_valid`=0, `busy`=0, `done`=0, `load_ready`=1.
  - Internal counters are cleared; the pattern in progress is discarded and `done` is not pulsed.

## Timing
- Load accepted at edge T:
  - First bit appears on `x` in cycle T+1.
  - Bit k of the sequence (k = 0 first) appears in cycle T+1+k.
- Single pass, length L: bits occupy cycles T+1..T+L; `done`=1 and `load_ready`=1 in cycle T+L+1.
- With repeat R: bits occupy T+1..T+L·(R+1) with no gaps; `done` is at T+L·(R+1)+1.
- Back-to-back loads:
  - A load may be accepted in the same cycle `done` is high.
  - Its first bit appears the next cycle, so at least one idle cycle (`x`=1) separates patterns.
- `len`==0 accepted at T: no SHIFT cycles; `done` pulses in cycle T+1; `x` stays 1.
- `load_valid` while busy is ignored; the source must hold it until `load_ready`.
- `busy` equals `bit_valid`. Both are registered with `x`, so all three change on the same edge.

## Configuration
- `PATTERN_SERIALIZER_REPEAT_EN` defined:
  - Repeat logic is compiled in.
  - `repeat_cnt` is captured at load and controls the number of passes as described.
- Not defined:
  - The pass counter is removed and `repeat_cnt` is ignored.
  - Every load produces exactly one pass of effLen bits followed by `done`.

## Test plan
- Reset then idle: hold reset 2 cycles, release -> `x`=1, `load_ready`=1, `busy`=0, `done`=0 every cycle.
- Single pass: load `pattern`=4'b0101, `len`=4, `repeat_cnt`=0 at T -> `x`=0,1,0,1 in T+1..T+4, `bit_valid`=1 in those cycles, `done`=1 at T+5, `x`=1 at T+5.
- Repeat (macro defined): `pattern`=3'b100, `len`=3, `repeat_cnt`=2 -> `x`=1,0,0,1,0,0,1,0,0 in T+1..T+9, `done` at T+10. With the macro undefined, the same stimulus gives `done` at T+4.
- Boundary lengths:
  - `len`=0 -> `done` at T+1, no `bit_valid`.
  - `len`=12 with MAXLEN=8 -> 8 bits `pattern`[7:0] sent, `done` at T+9.
- Back-to-back and busy: load during SHIFT is ignored (`load_ready`=0). A second load asserted on the `done` cycle is accepted and its first bit appears the following cycle.
- Reset mid-pattern: assert reset at the 2nd bit of an 8-bit pattern -> next cycle `x`=1, `busy`=0, no `done` pulse, `load_ready`=1.

Source files
------------

// File: rtl/pattern_serializer.sv
// pattern_serializer: loads a parallel pattern over a valid/ready port and
// shifts it out MSB-first on x, one bit per clock, holding x=1 when idle.
// Ports: clk, reset (sync, active-high); load_valid/load_ready handshake with
// pattern, len, repeat_cnt; outputs x, bit_valid, busy, done (all registered).
// Optional macro PATTERN_SERIALIZER_REPEAT_EN compiles in repeated passes.
module pattern_serializer #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int REPW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LENW-1:0]   len,
  input  logic [REPW-1:0]   repeat_cnt,
  output logic              x,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [LENW-1:0] MAXL = LENW'(MAXLEN);
  localparam logic [LENW-1:0] ONE  = LENW'(1);

  state_t            state;
  logic [MAXLEN-1:0] pat;
  logic [LENW-1:0]   idx;
  logic [LENW-1:0]   last;

  logic [LENW-1:0]   eff;
  logic [LENW-1:0]   eff_m1;
  logic [LENW-1:0]   idx_nxt;
  logic [MAXLEN-1:0] first_sh;
  logic [MAXLEN-1:0] next_sh;
  logic [MAXLEN-1:0] reload_sh;

`ifdef PATTERN_SERIALIZER_REPEAT_EN
  localparam logic [REPW-1:0] PONE = REPW'(1);
  logic [REPW-1:0] passes;
`else
  logic unused_rep;
  assign unused_rep = ^repeat_cnt;
`endif

  // Bit selection is done by shifting so the index width need not match
  // the pattern width.
  always_comb begin
    eff       = (len > MAXL) ? MAXL : len;
    eff_m1    = eff - ONE;
    idx_nxt   = idx - ONE;
    first_sh  = pattern >> eff_m1;
    next_sh   = pat >> idx_nxt;
    reload_sh = pat >> last;
  end

  assign load_ready = (state == IDLE);
  assign busy       = bit_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pat       <= '0;
      idx       <= '0;
      last      <= '0;
      x         <= 1'b1;
      bit_valid <= 1'b0;
      done      <= 1'b0;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
      passes    <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            if (eff == '0) begin
              // Empty pattern: no bits, just the completion pulse.
              done <= 1'b1;
            end else begin
              pat       <= pattern;
              idx       <= eff_m1;
              last      <= eff_m1;
              x         <= first_sh[0];
              bit_valid <= 1'b1;
              state     <= SHIFT;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
              passes    <= repeat_cnt;
`endif
            end
          end
        end
        SHIFT: begin
          if (idx == '0) begin
`ifdef PATTERN_SERIALIZER_REPEAT_EN
            if (passes != '0) begin
              // Next pass starts immediately, no gap.
              passes <= passes - PONE;
              idx    <= last;
              x      <= reload_sh[0];
            end else begin
              state     <= IDLE;
              x         <= 1'b1;
              bit_valid <= 1'b0;
              done      <= 1'b1;
            end
`else
            state     <= IDLE;
            x         <= 1'b1;
            bit_valid <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            idx <= idx_nxt;
            x   <= next_sh[0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed stimulus with a queue-based reference
// model compared every cycle, plus literal expectations per scenario.
module tb_pattern_serializer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [1:0] repeat_cnt;
  logic       x;
  logic       bit_valid;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  pattern_serializer #(.MAXLEN(8), .LENW(4), .REPW(2)) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .pattern(pattern),
    .len(len),
    .repeat_cnt(repeat_cnt),
    .x(x),
    .bit_valid(bit_valid),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each accepted load expands into the per-cycle list of
  // {x, bit_valid, done} it must produce; an empty list means idle.
  logic [2:0] q[$];
  logic m_x    = 1'b1;
  logic m_bv   = 1'b0;
  logic m_done = 1'b0;
  bit   chk_on = 1'b0;

  always @(posedge clk) begin
    int eff;
    int passes;
    logic [2:0] e;
    if (reset) begin
      q.delete();
      m_x = 1'b1;
      m_bv = 1'b0;
      m_done = 1'b0;
      chk_on = 1'b1;
    end else begin
      if (load_valid && !m_bv) begin
        eff = (int'(len) > 8) ? 8 : int'(len);
`ifdef PATTERN_SERIALIZER_REPEAT_EN
        passes = int'(repeat_cnt) + 1;
`else
        passes = 1;
`endif
        if (eff > 0)
          for (int p = 0; p < passes; p++)
            for (int k = eff - 1; k >= 0; k--)
              q.push_back({pattern[k], 1'b1, 1'b0});
        q.push_back(3'b101);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        m_x = e[2];
        m_bv = e[1];
        m_done = e[0];
      end else begin
        m_x = 1'b1;
        m_bv = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      tests++;
      if (x !== m_x || bit_valid !== m_bv || busy !== m_bv ||
          done !== m_done || load_ready !== !m_bv) begin
        fails++;
        $display("FAIL cycle_model t=%0t x=%b exp %b bv=%b exp %b busy=%b done=%b exp %b ready=%b",
                 $time, x, m_x, bit_valid, m_bv, busy, done, m_done, load_ready);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Load at the next edge, then collect bits until done (bounded).
  task automatic run_load(input string name, input logic [7:0] p,
                          input logic [3:0] l, input logic [1:0] r,
                          input int exp_bits, input int exp_n,
                          input int exp_done);
    int cyc;
    int n;
    int got;
    int dcyc;
    @(negedge clk);
    pattern = p;
    len = l;
    repeat_cnt = r;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    cyc = 1;
    n = 0;
    got = 0;
    dcyc = -1;
    for (int g = 0; g < 64; g++) begin
      if (bit_valid) begin
        got = (got << 1) | int'(x);
        n++;
      end
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, "_bits"}, got, exp_bits);
    check({name, "_nbits"}, n, exp_n);
    check({name, "_done_cycle"}, dcyc, exp_done);
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = 0;
    for (int g = 0; g < 64; g++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  initial begin
    int dcount;
    reset = 1'b1;
    load_valid = 1'b0;
    pattern = '0;
    len = '0;
    repeat_cnt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_x", int'(x), 1);
      check("idle_ready", int'(load_ready), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
    end

    run_load("single", 8'h05, 4'd4, 2'd0, 'b0101, 4, 5);
`ifdef PATTERN_SERIALIZER_REPEAT_EN
    run_load("repeat", 8'h04, 4'd3, 2'd2, 'b100100100, 9, 10);
`else
    run_load("repeat", 8'h04, 4'd3, 2'd2, 'b100, 3, 4);
`endif
    run_load("len0", 8'hFF, 4'd0, 2'd0, 0, 0, 1);
    run_load("len12", 8'hA5, 4'd12, 2'd0, 'hA5, 8, 9);

    // Loads offered while shifting must be ignored.
    @(negedge clk);
    pattern = 8'hF0;
    len = 4'd6;
    repeat_cnt = 2'd0;
    load_valid = 1'b1;
    @(negedge clk);
    pattern = 8'h0F;
    len = 4'd2;
    for (int i = 0; i < 3; i++) begin
      check("busy_ready", int'(load_ready), 0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    for (int g = 0; g < 64 && !done; g++) @(negedge clk);
    check("b2b_first_done", int'(done), 1);
    // Second load offered in the done cycle.
    pattern = 8'h03;
    len = 4'd3;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("b2b_first_bv", int'(bit_valid), 1);
    check("b2b_first_x", int'(x), 0);
    wait_done("b2b_second");

    // Reset while the 2nd bit is on the line.
    @(negedge clk);
    pattern = 8'hCA;
    len = 4'd8;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    check("mid_bit2_bv", int'(bit_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_x", int'(x), 1);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_ready", int'(load_ready), 1);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mid_no_done", dcount, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
